// File: rtl/vr_upsizer.sv
// vr_upsizer: packs RATIO narrow valid/ready beats into one wide word,
// flushing a partial word on i_last with contiguous per-lane keep bits.
module vr_upsizer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic [IN_WIDTH-1:0]       i_data,
    input  logic                      i_last,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [IN_WIDTH*RATIO-1:0] o_data,
    output logic [RATIO-1:0]          o_keep,
    output logic                      o_last
);
    localparam int CW = $clog2(RATIO);

    logic [CW-1:0]                  cnt_q;
    logic [RATIO-2:0][IN_WIDTH-1:0] acc_q;
    logic [RATIO-2:0]               mask_q;
    logic [RATIO-1:0][IN_WIDTH-1:0] word_d;
    logic [RATIO-1:0]               keep_d;
    logic [IN_WIDTH*RATIO-1:0]      data_q;
    logic [RATIO-1:0]               keep_q;
    logic                           last_q;
    logic                           vld_q;
    logic                           acc_en;
    logic                           done;

    assign o_rdy  = !vld_q || i_rdy;
    assign acc_en = i_vld && o_rdy;
    assign done   = acc_en && (i_last || cnt_q == CW'(RATIO - 1));
    assign o_vld  = vld_q;
    assign o_data = data_q;
    assign o_keep = keep_q;
    assign o_last = last_q;

    // The mask gates stale accumulator lanes so unfilled lanes leave as zero.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        if (k < RATIO - 1) begin : g_acc
            assign word_d[k] = (cnt_q == CW'(k)) ? i_data : mask_q[k] ? acc_q[k] : '0;
        end else begin : g_top
            assign word_d[k] = (cnt_q == CW'(k)) ? i_data : '0;
        end
        assign keep_d[k] = CW'(k) <= cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            mask_q <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            if (done) begin
                cnt_q  <= '0;
                mask_q <= '0;
                data_q <= word_d;
                keep_q <= keep_d;
                last_q <= i_last;
                vld_q  <= 1'b1;
            end else begin
                if (acc_en) begin
                    cnt_q          <= cnt_q + 1'b1;
                    acc_q[cnt_q]  <= i_data;
                    mask_q[cnt_q] <= 1'b1;
                end
                if (i_rdy) vld_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vr_upsizer.sv
// tb_vr_upsizer: directed packet table, corner sequences and randomized
// traffic checked against a queue-based packet model.
module tb_vr_upsizer;
    localparam int W = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_vld = 1'b0;
    logic           o_rdy;
    logic [W-1:0]   i_data = '0;
    logic           i_last = 1'b0;
    logic           o_vld;
    logic           i_rdy = 1'b0;
    logic [W*R-1:0] o_data;
    logic [R-1:0]   o_keep;
    logic           o_last;

    vr_upsizer #(.IN_WIDTH(W), .RATIO(R)) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_data(i_data),
        .i_last(i_last), .o_vld(o_vld), .i_rdy(i_rdy), .o_data(o_data),
        .o_keep(o_keep), .o_last(o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W*R-1:0] d;
        logic [R-1:0]   k;
        logic           l;
    } word_t;

    typedef struct {
        int             n;
        logic [W-1:0]   b0;
        logic [W-1:0]   inc;
        logic           lst;
        logic [W*R-1:0] ed;
        logic [R-1:0]   ek;
        logic           el;
    } pkt_t;

    int           n_chk = 0;
    int           n_fail = 0;
    int           n_acc = 0;
    word_t        q[$];
    logic [W-1:0] cur[$];
    pkt_t         tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict acceptance from the model, advance, compare.
    task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        logic  exp_rdy;
        word_t w;
        i_vld = v; i_data = d; i_last = l; i_rdy = r;
        #1;
        exp_rdy = (q.size() == 0) || r;
        chk("o_rdy", o_rdy, exp_rdy);
        if (q.size() > 0 && r) q.delete(0);
        if (v && exp_rdy) begin
            n_acc++;
            cur.push_back(d);
            if (cur.size() == R || l) begin
                w.d = '0;
                foreach (cur[k]) w.d |= (W*R)'(cur[k]) << (W * k);
                w.k = R'((1 << cur.size()) - 1);
                w.l = l;
                q.push_back(w);
                cur.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("o_vld", o_vld, q.size() > 0);
        if (q.size() > 0) begin
            chk("o_data", o_data, q[0].d);
            chk("o_keep", o_keep, q[0].k);
            chk("o_last", o_last, q[0].l);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_data", o_data, 0);
        chk("rst_keep", o_keep, 0);
        chk("rst_last", o_last, 0);
        @(posedge clk);
        #1;
        q.delete();
        cur.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4, 8'h11, 8'h11, 1'b1, 32'h44332211, 4'b1111, 1'b1};
        tbl[1] = '{2, 8'hA1, 8'h01, 1'b1, 32'h0000A2A1, 4'b0011, 1'b1};
        tbl[2] = '{4, 8'hB1, 8'h01, 1'b0, 32'hB4B3B2B1, 4'b1111, 1'b0};
        tbl[3] = '{1, 8'h5A, 8'h00, 1'b1, 32'h0000005A, 4'b0001, 1'b1};
        tbl[4] = '{3, 8'h01, 8'h01, 1'b1, 32'h00030201, 4'b0111, 1'b1};
        tbl[5] = '{4, 8'hF1, 8'h01, 1'b1, 32'hF4F3F2F1, 4'b1111, 1'b1};

        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);

        foreach (tbl[t]) begin
            for (int i = 0; i < tbl[t].n; i++)
                step(1'b1, tbl[t].b0 + W'(i) * tbl[t].inc, tbl[t].lst && i == tbl[t].n - 1, 1'b1);
            chk("tbl_vld", o_vld, 1);
            chk("tbl_data", o_data, tbl[t].ed);
            chk("tbl_keep", o_keep, tbl[t].ek);
            chk("tbl_last", o_last, tbl[t].el);
            step(1'b0, 8'hEE, 1'b1, 1'b1);
            chk("tbl_one_cycle", o_vld, 0);
        end

        for (int i = 0; i < R; i++) begin
            step(1'b1, 8'hE0 + W'(i), 1'b1, 1'b1);
            chk("single_keep", o_keep, 4'b0001);
            chk("single_data", o_data, 32'hE0 + i);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b1);
            if (i == 4) chk("stream_w0", o_data, 32'h04030201);
            if (i == 8) chk("stream_w1", o_data, 32'h08070605);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h05, 1'b0, 1'b0);
            chk("bp_rdy", o_rdy, 0);
            chk("bp_hold", o_data, 32'h04030201);
        end
        for (int i = 5; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b1);
        chk("bp_resume", o_data, 32'h08070605);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        step(1'b1, 8'hD1, 1'b0, 1'b1);
        step(1'b1, 8'hD2, 1'b0, 1'b1);
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'hC0 + W'(i), i == 4, 1'b1);
        chk("post_rst_data", o_data, 32'hC4C3C2C1);
        chk("post_rst_keep", o_keep, 4'b1111);

        for (int i = 0; i < 50; i++) step(1'b1, W'($urandom), ($urandom % 6) == 0, 1'b1);

        n_acc = 0;
        for (int c = 0; c < 6000 && n_acc < 1000; c++)
            step(($urandom % 4) != 0, W'($urandom), ($urandom % 5) == 0, ($urandom % 4) != 0);
        chk("random_beats", n_acc >= 1000, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vr_upsizer.md
Name: vr_upsizer

Overview:
- Valid/ready stream width upsizer. Packs RATIO consecutive narrow beats of IN_WIDTH bits into one wide word of IN_WIDTH*RATIO bits.
- Sits directly upstream of the pipeline register slice on the AXI example datapath and drives that slice's input handshake.
- A packet-end marker (i_last) flushes a partially filled word, with per-lane keep bits marking the valid lanes.

Parameters:
- IN_WIDTH, 8, width of one input beat in bits; must be ≥1.
- RATIO, 4, number of input beats per output word; must be ≥2 (power of two not required).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_vld  input  1  input beat valid.
- o_rdy  output  1  input beat accepted when i_vld && o_rdy.
- i_data  input  IN_WIDTH  input beat payload.
- i_last  input  1  beat is the final beat of a packet.
- o_vld  output  1  output word valid.
- i_rdy  input  1  downstream ready; word transferred when o_vld && i_rdy.
- o_data  output  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- o_keep  output  RATIO  lane k valid when bit k = 1.
- o_last  output  1  word ends a packet.

Behaviour:
- State:
  - lane counter cnt, width $clog2(RATIO), range 0..RATIO-1;
  - partial accumulator acc (IN_WIDTH*(RATIO-1) bits) with lane-valid mask;
  - output register (o_data, o_keep, o_last, o_vld).
- Reset (async, rst_n low):
  - cnt=0, accumulator and mask cleared;
  - o_vld=0, o_keep=0, o_last=0, o_data=0.
  - Reset mid-packet discards any partial word; the first beat after reset goes to lane 0.
- o_rdy = !o_vld || i_rdy, purely combinational. It never depends on i_vld, i_data or i_last.
- Accepted beat, fill position:
  - The beat is written to lane cnt (little-endian: first beat in lane 0).
- Accepted beat, non-completing (cnt < RATIO-1 and i_last=0):
  - Store the beat in acc lane cnt, set its mask bit, then cnt <= cnt+1.
  - The output register is unaffected, apart from the o_vld update rule below.
- Accepted beat, completing (cnt == RATIO-1, or i_last=1):
  - On the next edge the output register loads acc lanes 0..cnt-1 plus the incoming beat in lane cnt.
  - o_keep = lanes 0..cnt set, contiguous from LSB.
  - Unfilled lanes of o_data are forced to 0.
  - o_last = i_last; o_vld = 1.
  - cnt <= 0 and the accumulator mask is cleared in the same edge.
- o_vld update rule when no completing beat is accepted:
  - o_vld cleared on the edge where i_rdy=1.
  - Otherwise held with o_data/o_keep/o_last stable (no change while o_vld && !i_rdy).
- Simultaneous output transfer and completing beat: the new word replaces the old one and o_vld stays 1. Full throughput of one input beat per cycle with no bubbles.
- Latency: o_vld rises the cycle after the completing beat's handshake.
- Backpressure: while o_vld && !i_rdy, o_rdy=0 and no beats are accepted, including non-completing ones. Input data is never dropped.
- i_last on a beat with cnt == RATIO-1 yields a full word (o_keep all ones) with o_last=1.
- RATIO consecutive i_last beats each produce a one-lane word (o_keep = 1).
- i_vld low cycles between beats are allowed and do not disturb cnt or acc.
- Input signals are ignored when i_vld=0; i_last is only sampled on accepted beats.

Test Plan:
- IN_WIDTH=8, RATIO=4, i_rdy=1; send 0x11,0x22,0x33,0x44 (last on 0x44) on consecutive cycles -> one word o_data=0x44332211, o_keep=4'b1111, o_last=1, o_vld high exactly one cycle, one cycle after 0x44 accepted.
- Send 0xA1,0xA2 with i_last on 0xA2 -> o_data=0x0000A2A1, o_keep=4'b0011, o_last=1; next packet 0xB1.. lands in lane 0.
- Stream 8 beats 0x01..0x08 back-to-back, no last, i_rdy=1 -> words 0x04030201 then 0x08070605 on consecutive-eligible cycles, o_rdy constantly 1, o_last=0.
- Hold i_rdy=0 after the first word completes -> o_rdy=0, o_data stays 0x04030201 stable; release i_rdy -> transfer, beats resume with no loss or duplication.
- Assert rst_n low after 2 beats accepted, release, send 0xC1..0xC4 -> o_data=0xC4C3C2C1, o_keep=4'b1111; all outputs 0 during reset.
- Random i_vld/i_rdy toggling over 1000 beats with random i_last, checked against a reference model -> exact data, keep and last match; a sustained one-beat-per-cycle handshake never stalls while i_rdy=1.
